// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//  Shared constants for the RV32I write-back stage and register file.
//  XLEN   : data width of registers and write-back operands
//  NREGS  : number of architectural integer registers (x0 hardwired to zero)
//  AW     : register address width
//  wb_sel_e : write-back source select encoding (code 11 is reserved)
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_MEM  = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//  Architectural register file: NREGS x XLEN, two asynchronous read ports,
//  one synchronous write port. x0 always reads as zero and is never written.
//  Optional macro WB_BYPASS_EN: a read that matches the register being written
//  this cycle returns the write data instead of the stored value.
// Ports
//  clk, rst_n           : clock, asynchronous active-low reset (clears all regs)
//  we, wr_addr, wr_data : write port, committed on the rising edge
//  rs1_addr / rs1_data  : read port 1 (combinational)
//  rs2_addr / rs2_data  : read port 2 (combinational)
// -----------------------------------------------------------------------------
module regfile_2r1w #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [AW-1:0]   rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs2_data
);

   logic [XLEN-1:0] regs [NREGS];

   // Async reset keeps every register in flops; x0 is cleared by reset and the
   // write guard below means nothing ever changes it afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
      logic [XLEN-1:0] value;
      value = regs[addr];
`ifdef WB_BYPASS_EN
      if (we && (addr == wr_addr)) begin
         value = wr_data;
      end
`endif
      // Applied last so the zero rule also beats a bypassed value.
      if (addr == '0) begin
         value = '0;
      end
      return value;
   endfunction

   assign rs1_data = read_port(rs1_addr);
   assign rs2_data = read_port(rs2_addr);

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//  RV32I write-back stage plus integer register file. Selects the write-back
//  value from the MEM/WB outputs, qualifies the write enable, commits to rd
//  and serves two combinational operand reads. Keeps a 64-bit instret count.
//  Optional macro WB_BYPASS_EN enables write-to-read bypass in the reg file.
// Ports
//  clk, rst_n                   : clock, asynchronous active-low reset
//  wb_valid, wb_reg_write       : slot holds an instruction / it writes rd
//  wb_mem_to_reg, wb_sel        : write-back source select
//  wb_pc_plus_4, wb_alu_result,
//  wb_mem_data, wb_rd_addr      : write-back operands and destination
//  rs1_addr/rs1_data,
//  rs2_addr/rs2_data            : operand read ports (combinational)
//  wb_data, wb_we               : selected value / qualified enable (comb.)
//  instret_clr, instret         : synchronous clear / retired count
// -----------------------------------------------------------------------------
module wb_regfile #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int NREGS = riscv_pkg::NREGS,
   parameter int AW    = riscv_pkg::AW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_valid,
   input  logic            wb_reg_write,
   input  logic            wb_mem_to_reg,
   input  logic [1:0]      wb_sel,
   input  logic [XLEN-1:0] wb_pc_plus_4,
   input  logic [XLEN-1:0] wb_alu_result,
   input  logic [XLEN-1:0] wb_mem_data,
   input  logic [AW-1:0]   wb_rd_addr,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_we,
   input  logic            instret_clr,
   output logic [63:0]     instret
);

   import riscv_pkg::*;

   logic [63:0] instret_reg;

   // A load forces the memory path regardless of wb_sel; the reserved
   // select code falls back to the ALU value.
   always_comb begin
      wb_data = wb_alu_result;
      if (wb_mem_to_reg) begin
         wb_data = wb_mem_data;
      end else begin
         case (wb_sel_e'(wb_sel))
            WB_SEL_MEM: wb_data = wb_mem_data;
            WB_SEL_PC4: wb_data = wb_pc_plus_4;
            default:    wb_data = wb_alu_result;
         endcase
      end
   end

   assign wb_we = wb_valid && wb_reg_write && (wb_rd_addr != '0);

   regfile_2r1w #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wb_we),
      .wr_addr  (wb_rd_addr),
      .wr_data  (wb_data),
      .rs1_addr (rs1_addr),
      .rs1_data (rs1_data),
      .rs2_addr (rs2_addr),
      .rs2_data (rs2_data)
   );

   // Every valid slot retires, including stores and branches. Clear has
   // priority over the increment; the add wraps silently at 2^64.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_reg <= '0;
      end else if (instret_clr) begin
         instret_reg <= '0;
      end else if (wb_valid) begin
         instret_reg <= instret_reg + 64'd1;
      end
   end

   assign instret = instret_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//  Self-checking bench for wb_regfile. Expected register contents are pushed
//  to a queue when a write is driven and popped/compared after commit.
//  Honours WB_BYPASS_EN for the same-cycle read expectation.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_reg_write;
   logic        wb_mem_to_reg;
   logic [1:0]  wb_sel;
   logic [31:0] wb_pc_plus_4;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_mem_data;
   logic [4:0]  wb_rd_addr;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic        wb_we;
   logic        instret_clr;
   logic [63:0] instret;

   typedef struct {
      string       tag;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_regs [32];
   logic [63:0] model_instret;
   int          checks;
   int          failures;

   wb_regfile dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_sel        (wb_sel),
      .wb_pc_plus_4  (wb_pc_plus_4),
      .wb_alu_result (wb_alu_result),
      .wb_mem_data   (wb_mem_data),
      .wb_rd_addr    (wb_rd_addr),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .wb_data       (wb_data),
      .wb_we         (wb_we),
      .instret_clr   (instret_clr),
      .instret       (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s value=0x%0h", tag, got);
      end
   endtask

   // Drive one MEM/WB slot at the negedge, check the combinational outputs,
   // let it commit, then check instret against the model.
   task automatic do_wb(input string tag, input logic v, input logic rw, input logic m2r,
                        input logic [1:0] sel, input logic [31:0] pc4, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [4:0] rd);
      logic [31:0] exp_d;
      logic        exp_we;
      wb_valid      = v;
      wb_reg_write  = rw;
      wb_mem_to_reg = m2r;
      wb_sel        = sel;
      wb_pc_plus_4  = pc4;
      wb_alu_result = alu;
      wb_mem_data   = mem;
      wb_rd_addr    = rd;
      if (m2r || sel == 2'b01) exp_d = mem;
      else if (sel == 2'b10)   exp_d = pc4;
      else                     exp_d = alu;
      exp_we = v && rw && (rd != 5'd0);
      #1;
      check_eq({tag, "_wb_data"}, {32'd0, wb_data}, {32'd0, exp_d});
      check_eq({tag, "_wb_we"}, {63'd0, wb_we}, {63'd0, exp_we});
      if (exp_we) begin
         model_regs[rd] = exp_d;
         exp_q.push_back('{tag, rd, exp_d});
      end
      if (v) model_instret = model_instret + 64'd1;
      @(posedge clk);
      #1;
      wb_valid     = 1'b0;
      wb_reg_write = 1'b0;
      check_eq({tag, "_instret"}, instret, model_instret);
      @(negedge clk);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rs1_addr = e.addr;
         rs2_addr = e.addr;
         #1;
         check_eq({e.tag, "_rs1"}, {32'd0, rs1_data}, {32'd0, e.data});
         check_eq({e.tag, "_rs2"}, {32'd0, rs2_data}, {32'd0, e.data});
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back('{$sformatf("%s_x%0d", tag, i), 5'(i), 32'd0});
      end
      drain();
   endtask

   initial begin
      logic [31:0] exp_byp;
      checks        = 0;
      failures      = 0;
      model_instret = '0;
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      rst_n         = 1'b0;
      wb_valid      = 1'b0;
      wb_reg_write  = 1'b0;
      wb_mem_to_reg = 1'b0;
      wb_sel        = 2'b00;
      wb_pc_plus_4  = '0;
      wb_alu_result = '0;
      wb_mem_data   = '0;
      wb_rd_addr    = '0;
      rs1_addr      = '0;
      rs2_addr      = '0;
      instret_clr   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check_eq("reset_instret", instret, 64'd0);
      check_all_zero("reset");

      // Write-back source selection
      do_wb("alu_x5", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0011, 5'd5);
      do_wb("pc4_x1", 1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0104, 32'h0000_0022, 32'h0000_0033, 5'd1);
      do_wb("m2r_x3", 1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_0044, 32'h0000_0099, 32'h0000_0055, 5'd3);
      do_wb("mem_x6", 1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0001, 32'h0000_0002, 32'h0000_CAFE, 5'd6);
      do_wb("rsv_x4", 1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_0888, 32'h0000_0777, 32'h0000_0999, 5'd4);
      do_wb("max_x31", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h8000_0001, 32'h0, 5'd31);
      drain();

      // x0 is never written
      do_wb("x0_write", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0);
      exp_q.push_back('{"x0_read", 5'd0, 32'd0});
      drain();

      // Bubble: no write, no retire
      do_wb("x7_init", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0000_1111, 32'h0, 5'd7);
      do_wb("bubble", 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0000_2222, 32'h0, 5'd7);
      exp_q.push_back('{"bubble_x7", 5'd7, model_regs[7]});
      drain();

      // Valid without reg_write still retires (store/branch) and writes nothing
      do_wb("store_x5", 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0BAD_0BAD, 32'h0, 5'd5);
      exp_q.push_back('{"store_x5", 5'd5, model_regs[5]});
      drain();

      // Same-cycle write/read of x9
      do_wb("x9_init", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0000_AAAA, 32'h0, 5'd9);
      drain();
      wb_valid      = 1'b1;
      wb_reg_write  = 1'b1;
      wb_mem_to_reg = 1'b0;
      wb_sel        = 2'b00;
      wb_alu_result = 32'h0000_1234;
      wb_rd_addr    = 5'd9;
      rs1_addr      = 5'd5;
      rs2_addr      = 5'd9;
`ifdef WB_BYPASS_EN
      exp_byp = 32'h0000_1234;
`else
      exp_byp = model_regs[9];
`endif
      #1;
      check_eq("bypass_rs2", {32'd0, rs2_data}, {32'd0, exp_byp});
      check_eq("bypass_rs1_other", {32'd0, rs1_data}, {32'd0, model_regs[5]});
      model_regs[9] = 32'h0000_1234;
      model_instret = model_instret + 64'd1;
      exp_q.push_back('{"bypass_commit", 5'd9, 32'h0000_1234});
      @(posedge clk);
      #1;
      wb_valid     = 1'b0;
      wb_reg_write = 1'b0;
      check_eq("bypass_instret", instret, model_instret);
      @(negedge clk);
      drain();

      // Clear wins over a same-cycle retire
      wb_valid    = 1'b1;
      instret_clr = 1'b1;
      model_instret = '0;
      @(posedge clk);
      #1;
      wb_valid    = 1'b0;
      instret_clr = 1'b0;
      check_eq("clr_valid", instret, model_instret);
      @(negedge clk);
      do_wb("after_clr", 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);

      // Wrap: preload all-ones, then one retire
      force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_reg;
      #1;
      check_eq("preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      model_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      do_wb("wrap", 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);

      // Reset mid-operation: in-flight write is discarded
      do_wb("x10_init", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0000_7777, 32'h0, 5'd10);
      drain();
      wb_valid      = 1'b1;
      wb_reg_write  = 1'b1;
      wb_alu_result = 32'h0000_5555;
      wb_rd_addr    = 5'd10;
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_instret", instret, 64'd0);
      @(posedge clk);
      #1;
      wb_valid     = 1'b0;
      wb_reg_write = 1'b0;
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      model_instret = '0;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("post_rst_instret", instret, model_instret);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
